// File: rtl/rvx_mem_pkg.sv
// rvx_mem_pkg: shared types and widths for the RVX10 data-memory responder.
//   dmem_state_t : responder FSM state encoding (IDLE, WAIT, RESP)
//   WORD_W       : data word width
//   BE_W         : byte-enable width (one bit per byte lane)
//   CNT_W        : wait-state counter width (LATENCY range 0..15)
package rvx_mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous word-addressed storage with byte-lane writes.
// Ports:
//   clk    in  clock
//   we     in  write strobe; enabled lanes of wdata are written at the edge
//   be     in  byte enables, bit i covers wdata[8i+7:8i]
//   idx    in  word index shared by the write and read ports
//   wdata  in  write data, lane-aligned
//   re     in  read strobe; rdata captures mem[idx] at the edge
//   rdata  out registered read word, held until the next read strobe
// Contents are not reset.
module dmem_array
  import rvx_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder for the RVX10 Memory stage.
// One request at a time is accepted over req_valid/req_ready, served from
// dmem_array, and answered over rsp_valid/rsp_ready after LATENCY wait states.
// Optional build macro: DMEM_ERR_EN enables rejection of misaligned or
// out-of-range addresses; without it addresses wrap modulo 4*DEPTH and
// rsp_err is always 0.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_addr           1 = store / 0 = load, byte address
//   req_wdata, req_be          store data and byte enables
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_err         load word (0 for stores/errors), reject flag
//   busy                       a transaction is outstanding
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; store/array read happen on the accept edge
// WAIT  | counting wait states; loaded with LATENCY, RESP after it hits 0,
//       | so rsp_valid rises LATENCY+1 edges after acceptance
// RESP  | response presented and held until rsp_ready
module dmem_responder
  import rvx_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              rsp_err_q;
  logic              rsp_load_q;
  logic              accept;
  logic              err;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] arr_rdata;

  assign idx = req_addr[AW+1:2];

`ifdef DMEM_ERR_EN
  assign err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
`else
  logic unused_addr_bits;
  assign err              = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // Gated with reset so the unreset array cannot be written while the
  // controller is held in reset with req_ready high.
  assign accept = (state == IDLE) && req_valid && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= WAIT;
            cnt        <= CNT_W'(LATENCY);
            rsp_err_q  <= err;
            rsp_load_q <= !req_we && !err;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (accept && req_we && !err),
    .be    (req_be),
    .idx   (idx),
    .wdata (req_wdata),
    .re    (accept && !req_we && !err),
    .rdata (arr_rdata)
  );

  // Response outputs are forced to zero outside RESP so reset clears them
  // immediately without resetting the array read register.
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (rsp_valid && rsp_load_q) ? arr_rdata : '0;
  assign rsp_err   = rsp_valid && rsp_err_q;

endmodule
